cordic_pair_scheduler: RTL and testbench

CORDIC_PAIR_SCHEDULER -- requirements
Module: cordic_pair_scheduler

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_tag_fifo.sv | 61 ++++++
 rtl/cordic_pair_scheduler.sv | 167 ++++++++++++++++
 tb/tb_cordic_pair_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared widths, FSM encoding and requester-id type for the CORDIC pair scheduler slice.
package cordic_pkg;

   localparam int CORDIC_DATA_WIDTH_DEF = 22;
   localparam int FLOAT_DATA_WIDTH_DEF  = 32;
   localparam int TAG_DEPTH_DEF         = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ISSUE_ONE = 2'b01,
      ISSUE_TWO = 2'b10
   } schedState_t;

   typedef logic reqId_t;

   function automatic logic [1:0] idToOneHot(input reqId_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// Owner-id FIFO tracking which requester each in-flight CORDIC operation belongs to.
// The caller gates push against full and pop against empty.
module cordic_tag_fifo
   import cordic_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  reqId_t                   id_in,
   output reqId_t                   id_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne  = 1;
   localparam logic [AW:0]   CntOne  = 1;
   localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);

   reqId_t        r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;

   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wrPtr] <= id_in;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_wrPtr <= r_wrPtr + PtrOne;
         end
         if (pop) begin
            r_rdPtr <= r_rdPtr + PtrOne;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + CntOne;
            2'b01:   r_count <= r_count - CntOne;
            default: r_count <= r_count;
         endcase
      end
   end

   assign id_out = r_mem[r_rdPtr];
   assign count  = r_count;
   assign full   = (r_count == CntFull);
   assign empty  = (r_count == '0);

endmodule

// File: rtl/cordic_pair_scheduler.sv
// Round-robin scheduler issuing operand pairs from two requesters into one CORDIC pipeline.
// Optional fault detection is enabled by defining CORDIC_SCHED_ERR_EN.
module cordic_pair_scheduler
   import cordic_pkg::*;
#(
   parameter int CORDIC_DATA_WIDTH = CORDIC_DATA_WIDTH_DEF,
   parameter int FLOAT_DATA_WIDTH  = FLOAT_DATA_WIDTH_DEF,
   parameter int TAG_DEPTH         = TAG_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clk_en,
   input  logic [1:0]                    req,
   input  logic [CORDIC_DATA_WIDTH-1:0]  x_one_0,
   input  logic [CORDIC_DATA_WIDTH-1:0]  x_two_0,
   input  logic [CORDIC_DATA_WIDTH-1:0]  x_one_1,
   input  logic [CORDIC_DATA_WIDTH-1:0]  x_two_1,
   output logic [1:0]                    grant,
   output logic [CORDIC_DATA_WIDTH-1:0]  cp_target,
   output logic                          cp_start,
   input  logic [CORDIC_DATA_WIDTH-1:0]  cp_result,
   input  logic [FLOAT_DATA_WIDTH-1:0]   cp_squared,
   input  logic                          cp_valid,
   output logic [1:0]                    rsp_valid,
   output logic [CORDIC_DATA_WIDTH-1:0]  rsp_result,
   output logic [FLOAT_DATA_WIDTH-1:0]   rsp_squared,
   output logic                          busy,
   output logic                          error
);

   localparam int CW = $clog2(TAG_DEPTH) + 1;
   localparam logic [CW-1:0] GrantLimit = CW'(TAG_DEPTH - 2);

   schedState_t                  r_state;
   logic [1:0]                   r_grant;
   reqId_t                       r_lastServed;
   reqId_t                       r_owner;
   logic [CORDIC_DATA_WIDTH-1:0] r_xOne;
   logic [CORDIC_DATA_WIDTH-1:0] r_xTwo;
   logic [CORDIC_DATA_WIDTH-1:0] r_cpTarget;
   logic                         r_cpStart;
   logic [1:0]                   r_rspValid;
   logic [CORDIC_DATA_WIDTH-1:0] r_rspResult;
   logic [FLOAT_DATA_WIDTH-1:0]  r_rspSquared;

   reqId_t         w_winner;
   reqId_t         w_headId;
   logic [CW-1:0]  w_count;
   logic           w_full;
   logic           w_empty;
   logic           w_issuing;
   logic           w_push;
   logic           w_pop;
   logic           w_canGrant;

   always_comb begin
      w_winner = r_lastServed;
      if (req == 2'b11) begin
         w_winner = ~r_lastServed;
      end else if (req[1]) begin
         w_winner = 1'b1;
      end else begin
         w_winner = 1'b0;
      end
   end

   assign w_issuing  = clk_en && ((r_state == ISSUE_ONE) || (r_state == ISSUE_TWO));
   assign w_pop      = cp_valid && !w_empty;
   assign w_push     = w_issuing && (!w_full || w_pop);
   assign w_canGrant = clk_en && (|req) && (w_count <= GrantLimit);

   cordic_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tagFifo (
      .clk    (clk),
      .rst    (rst),
      .push   (w_push),
      .pop    (w_pop),
      .id_in  (r_owner),
      .id_out (w_headId),
      .count  (w_count),
      .full   (w_full),
      .empty  (w_empty)
   );

   // Issue FSM: a granted pair occupies two start cycles, then returns to IDLE for arbitration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_grant      <= 2'b00;
         r_lastServed <= 1'b0;
         r_owner      <= 1'b0;
         r_xOne       <= '0;
         r_xTwo       <= '0;
         r_cpTarget   <= '0;
         r_cpStart    <= 1'b0;
      end else begin
         r_grant   <= 2'b00;
         r_cpStart <= 1'b0;
         if (clk_en) begin
            unique case (r_state)
               IDLE: begin
                  if (w_canGrant) begin
                     r_grant      <= idToOneHot(w_winner);
                     r_owner      <= w_winner;
                     r_lastServed <= ~r_lastServed;
                     r_xOne       <= w_winner ? x_one_1 : x_one_0;
                     r_xTwo       <= w_winner ? x_two_1 : x_two_0;
                     r_state      <= ISSUE_ONE;
                  end
               end
               ISSUE_ONE: begin
                  r_cpTarget <= r_xOne;
                  r_cpStart  <= 1'b1;
                  r_state    <= ISSUE_TWO;
               end
               ISSUE_TWO: begin
                  r_cpTarget <= r_xTwo;
                  r_cpStart  <= 1'b1;
                  r_state    <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Result return ignores clk_en so the pipeline can always drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rspValid   <= 2'b00;
         r_rspResult  <= '0;
         r_rspSquared <= '0;
      end else if (w_pop) begin
         r_rspValid   <= idToOneHot(w_headId);
         r_rspResult  <= cp_result;
         r_rspSquared <= cp_squared;
      end else begin
         r_rspValid <= 2'b00;
      end
   end

`ifdef CORDIC_SCHED_ERR_EN
   logic r_error;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_error <= 1'b0;
      end else if ((cp_valid && w_empty) || (w_issuing && w_full && !w_pop)) begin
         r_error <= 1'b1;
      end
   end

   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   assign grant       = r_grant;
   assign cp_target   = r_cpTarget;
   assign cp_start    = r_cpStart;
   assign rsp_valid   = r_rspValid;
   assign rsp_result  = r_rspResult;
   assign rsp_squared = r_rspSquared;
   assign busy        = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_cordic_pair_scheduler.sv
// Self-checking bench for cordic_pair_scheduler: a directed vector table plus hand-written
// sequences for arbitration, FIFO fill, push/pop overlap, clock-enable hold and mid-pair reset.
module tb_cordic_pair_scheduler;

   localparam int CW = 22;
   localparam int FW = 32;
   localparam int TD = 16;
`ifdef CORDIC_SCHED_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          rstN = 1'b0;
   logic          clkEn = 1'b0;
   logic [1:0]    req = 2'b00;
   logic [CW-1:0] xOne0 = '0;
   logic [CW-1:0] xTwo0 = '0;
   logic [CW-1:0] xOne1 = '0;
   logic [CW-1:0] xTwo1 = '0;
   logic [CW-1:0] cpResult = '0;
   logic [FW-1:0] cpSquared = '0;
   logic          cpValid = 1'b0;

   logic [1:0]    grant;
   logic [CW-1:0] cpTarget;
   logic          cpStart;
   logic [1:0]    rspValid;
   logic [CW-1:0] rspResult;
   logic [FW-1:0] rspSquared;
   logic          busy;
   logic          error;

   int checkCount = 0;
   int errorCount = 0;
   int expOwners[$];

   typedef struct {
      logic [1:0]    req;
      logic          clkEn;
      logic          cpValid;
      logic [CW-1:0] cpResult;
      logic [FW-1:0] cpSquared;
      logic [1:0]    expGrant;
      logic          expStart;
      logic [CW-1:0] expTarget;
      logic [1:0]    expRsp;
      logic [CW-1:0] expResult;
      logic [FW-1:0] expSquared;
      logic          expBusy;
      logic          expError;
   } vector_t;

   vector_t vecs [8];

   always #5 clock = ~clock;

   cordic_pair_scheduler #(
      .CORDIC_DATA_WIDTH (CW),
      .FLOAT_DATA_WIDTH  (FW),
      .TAG_DEPTH         (TD)
   ) dut (
      .clk         (clock),
      .rst         (rstN),
      .clk_en      (clkEn),
      .req         (req),
      .x_one_0     (xOne0),
      .x_two_0     (xTwo0),
      .x_one_1     (xOne1),
      .x_two_1     (xTwo1),
      .grant       (grant),
      .cp_target   (cpTarget),
      .cp_start    (cpStart),
      .cp_result   (cpResult),
      .cp_squared  (cpSquared),
      .cp_valid    (cpValid),
      .rsp_valid   (rspValid),
      .rsp_result  (rspResult),
      .rsp_squared (rspSquared),
      .busy        (busy),
      .error       (error)
   );

   // Hard stop in case a sequence never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [1:0] ownerHot(input int id);
      return (id == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_grant"},   32'(grant),      32'd0);
      checkOutput({tag, "_start"},   32'(cpStart),    32'd0);
      checkOutput({tag, "_target"},  32'(cpTarget),   32'd0);
      checkOutput({tag, "_rsp"},     32'(rspValid),   32'd0);
      checkOutput({tag, "_result"},  32'(rspResult),  32'd0);
      checkOutput({tag, "_squared"}, rspSquared,      32'd0);
      checkOutput({tag, "_busy"},    32'(busy),       32'd0);
      checkOutput({tag, "_error"},   32'(error),      32'd0);
   endtask

   task automatic doReset(input string tag);
      req     = 2'b00;
      cpValid = 1'b0;
      clkEn   = 1'b1;
      rstN    = 1'b0;
      #2;
      checkResetState(tag);
      @(posedge clock);
      #1;
      rstN = 1'b1;
      expOwners.delete();
   endtask

   task automatic applyStimulus(input vector_t v);
      req       = v.req;
      clkEn     = v.clkEn;
      cpValid   = v.cpValid;
      cpResult  = v.cpResult;
      cpSquared = v.cpSquared;
      stepCycle();
   endtask

   task automatic checkVector(input int i, input vector_t v);
      checkOutput($sformatf("vec%0d_grant", i),   32'(grant),     32'(v.expGrant));
      checkOutput($sformatf("vec%0d_start", i),   32'(cpStart),   32'(v.expStart));
      checkOutput($sformatf("vec%0d_target", i),  32'(cpTarget),  32'(v.expTarget));
      checkOutput($sformatf("vec%0d_rsp", i),     32'(rspValid),  32'(v.expRsp));
      checkOutput($sformatf("vec%0d_result", i),  32'(rspResult), 32'(v.expResult));
      checkOutput($sformatf("vec%0d_squared", i), rspSquared,     v.expSquared);
      checkOutput($sformatf("vec%0d_busy", i),    32'(busy),      32'(v.expBusy));
      checkOutput($sformatf("vec%0d_error", i),   32'(error),     32'(v.expError));
   endtask

   task automatic issuePair(input int id);
      int waited = 0;
      req = ownerHot(id);
      do begin
         stepCycle();
         waited++;
      end while (grant == 2'b00 && waited < 20);
      checkOutput($sformatf("issueGrant_req%0d", id), 32'(grant), 32'(ownerHot(id)));
      req = 2'b00;
      stepCycle();
      stepCycle();
      expOwners.push_back(id);
      expOwners.push_back(id);
   endtask

   task automatic drainOwners(input string tag);
      int n = expOwners.size();
      cpValid = 1'b1;
      for (int j = 0; j < n; j++) begin
         cpResult = CW'(j + 1);
         stepCycle();
         checkOutput($sformatf("%s_owner%0d", tag, j), 32'(rspValid), 32'(ownerHot(expOwners.pop_front())));
         checkOutput($sformatf("%s_result%0d", tag, j), 32'(rspResult), 32'(j + 1));
      end
      cpValid = 1'b0;
      stepCycle();
      checkOutput({tag, "_rspIdle"}, 32'(rspValid), 32'd0);
      checkOutput({tag, "_busyIdle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int grantCount;
      int waited;
      int owner;
      logic [1:0] expGrant;

      // Single requester 0 pair, its two results, then a stray cp_valid and a clk_en=0 idle cycle.
      vecs[0] = '{2'b01, 1'b1, 1'b0, 22'h0,   32'h0,    2'b01, 1'b0, 22'h0,   2'b00, 22'h0,   32'h0,    1'b1, 1'b0};
      vecs[1] = '{2'b00, 1'b1, 1'b0, 22'h0,   32'h0,    2'b00, 1'b1, 22'h100, 2'b00, 22'h0,   32'h0,    1'b1, 1'b0};
      vecs[2] = '{2'b00, 1'b1, 1'b0, 22'h0,   32'h0,    2'b00, 1'b1, 22'h200, 2'b00, 22'h0,   32'h0,    1'b1, 1'b0};
      vecs[3] = '{2'b00, 1'b1, 1'b1, 22'h111, 32'h1000, 2'b00, 1'b0, 22'h200, 2'b01, 22'h111, 32'h1000, 1'b1, 1'b0};
      vecs[4] = '{2'b00, 1'b1, 1'b1, 22'h222, 32'h2000, 2'b00, 1'b0, 22'h200, 2'b01, 22'h222, 32'h2000, 1'b0, 1'b0};
      vecs[5] = '{2'b00, 1'b1, 1'b0, 22'h0,   32'h0,    2'b00, 1'b0, 22'h200, 2'b00, 22'h222, 32'h2000, 1'b0, 1'b0};
      vecs[6] = '{2'b00, 1'b1, 1'b1, 22'h333, 32'h3000, 2'b00, 1'b0, 22'h200, 2'b00, 22'h222, 32'h2000, 1'b0, ErrEn};
      vecs[7] = '{2'b00, 1'b0, 1'b0, 22'h0,   32'h0,    2'b00, 1'b0, 22'h200, 2'b00, 22'h222, 32'h2000, 1'b0, ErrEn};

      $display("[TB] starting");
      xOne0 = 22'h00100;
      xTwo0 = 22'h00200;
      xOne1 = 22'h00777;
      xTwo1 = 22'h00888;
      doReset("reset0");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Both requesters held: grants alternate starting with requester 1, one every 3 cycles.
      xOne0 = 22'h00010;
      xTwo0 = 22'h00020;
      xOne1 = 22'h00011;
      xTwo1 = 22'h00021;
      doReset("reset1");
      req = 2'b11;
      for (int k = 0; k < 12; k++) begin
         stepCycle();
         owner = ((k / 3) % 2 == 0) ? 1 : 0;
         expGrant = (k % 3 == 0) ? ownerHot(owner) : 2'b00;
         checkOutput($sformatf("altGrant%0d", k), 32'(grant), 32'(expGrant));
         checkOutput($sformatf("altStart%0d", k), 32'(cpStart), (k % 3 == 0) ? 32'd0 : 32'd1);
         if (k % 3 == 0) begin
            expOwners.push_back(owner);
            expOwners.push_back(owner);
         end else if (k % 3 == 1) begin
            checkOutput($sformatf("altTargetOne%0d", k), 32'(cpTarget), 32'(owner == 1 ? xOne1 : xOne0));
         end else begin
            checkOutput($sformatf("altTargetTwo%0d", k), 32'(cpTarget), 32'(owner == 1 ? xTwo1 : xTwo0));
         end
      end
      req = 2'b00;
      drainOwners("altDrain");

      // No results return: exactly 8 pairs fit before the free-entry check blocks arbitration.
      doReset("reset2");
      req = 2'b01;
      grantCount = 0;
      for (int k = 0; k < 40; k++) begin
         stepCycle();
         if (grant != 2'b00) grantCount++;
      end
      checkOutput("fillGrantCount", 32'(grantCount), 32'd8);
      checkOutput("fillBusy", 32'(busy), 32'd1);
      cpValid = 1'b1;
      stepCycle();
      checkOutput("fillPop0", 32'(rspValid), 32'(2'b01));
      stepCycle();
      checkOutput("fillPop1", 32'(rspValid), 32'(2'b01));
      checkOutput("fillNoEarlyGrant", 32'(grant), 32'd0);
      cpValid = 1'b0;
      waited = 0;
      do begin
         stepCycle();
         waited++;
      end while (grant == 2'b00 && waited < 5);
      checkOutput("fillResumeGrant", 32'(grant), 32'(2'b01));
      checkOutput("fillResumeLatency", 32'(waited), 32'd1);
      req = 2'b00;

      // Push and pop on the same edge with 5 tags queued.
      doReset("reset3");
      issuePair(0);
      issuePair(1);
      issuePair(0);
      cpValid = 1'b1;
      stepCycle();
      checkOutput("overlapPrePop", 32'(rspValid), 32'(ownerHot(expOwners.pop_front())));
      cpValid = 1'b0;
      req = 2'b10;
      stepCycle();
      checkOutput("overlapGrant", 32'(grant), 32'(2'b10));
      req = 2'b00;
      cpValid = 1'b1;
      stepCycle();
      checkOutput("overlapPopOwner", 32'(rspValid), 32'(ownerHot(expOwners.pop_front())));
      checkOutput("overlapStart", 32'(cpStart), 32'd1);
      expOwners.push_back(1);
      cpValid = 1'b0;
      stepCycle();
      expOwners.push_back(1);
      checkOutput("overlapQueueLen", 32'(expOwners.size()), 32'd6);
      drainOwners("overlapDrain");

      // clk_en low freezes the pair mid-issue while results still return.
      xOne0 = 22'h00ABC;
      xTwo0 = 22'h00DEF;
      doReset("reset4");
      req = 2'b01;
      stepCycle();
      checkOutput("holdGrant", 32'(grant), 32'(2'b01));
      req = 2'b00;
      clkEn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stepCycle();
         checkOutput($sformatf("holdStart%0d", k), 32'(cpStart), 32'd0);
         checkOutput($sformatf("holdTarget%0d", k), 32'(cpTarget), 32'd0);
         checkOutput($sformatf("holdBusy%0d", k), 32'(busy), 32'd1);
      end
      clkEn = 1'b1;
      stepCycle();
      checkOutput("holdResumeOne", 32'(cpTarget), 32'(xOne0));
      checkOutput("holdResumeStart", 32'(cpStart), 32'd1);
      stepCycle();
      checkOutput("holdResumeTwo", 32'(cpTarget), 32'(xTwo0));
      clkEn = 1'b0;
      cpValid = 1'b1;
      stepCycle();
      checkOutput("holdPop0", 32'(rspValid), 32'(2'b01));
      checkOutput("holdPopStart", 32'(cpStart), 32'd0);
      stepCycle();
      checkOutput("holdPop1", 32'(rspValid), 32'(2'b01));
      cpValid = 1'b0;
      clkEn = 1'b1;
      stepCycle();
      checkOutput("holdIdleBusy", 32'(busy), 32'd0);

      // Asynchronous reset while the second operand of a pair is being issued.
      xOne1 = 22'h003A5;
      doReset("reset5");
      req = 2'b11;
      stepCycle();
      checkOutput("midGrant", 32'(grant), 32'(2'b10));
      stepCycle();
      checkOutput("midStartOne", 32'(cpStart), 32'd1);
      checkOutput("midTargetOne", 32'(cpTarget), 32'(xOne1));
      #2;
      rstN = 1'b0;
      #1;
      checkResetState("midReset");
      #1;
      rstN = 1'b1;
      req = 2'b00;
      #1;
      checkOutput("midReleaseBusy", 32'(busy), 32'd0);
      cpValid = 1'b1;
      stepCycle();
      checkOutput("midNoRsp", 32'(rspValid), 32'd0);
      checkOutput("midEmptyError", 32'(error), 32'(ErrEn));
      cpValid = 1'b0;
      req = 2'b11;
      stepCycle();
      checkOutput("midNextGrant", 32'(grant), 32'(2'b10));
      req = 2'b00;
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
